// File: rtl/ifid_pipe_ctrl.sv
// Front-end pipeline sequencer: owns the fetch PC and resolves start/halt/branch/load-use
// into per-cycle IF/ID enable/flush and ID/EX bubble controls.
module ifid_pipe_ctrl #(
    parameter logic [7:0]  RESET_PC     = 8'h00,
    parameter logic [7:0]  PC_STEP      = 8'd1,
    parameter int unsigned STALL_CYCLES = 1
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       start,
    input  logic       halt_req,
    input  logic       branch_taken,
    input  logic [7:0] branch_target,
    input  logic       lu_hazard,
    output logic [7:0] pc,
    output logic       pc_en,
    output logic       ifid_en,
    output logic       ifid_flush,
    output logic       idex_bubble,
    output logic       busy,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_RUN   = 2'b01,
        S_STALL = 2'b10,
        S_HALT  = 2'b11
    } state_t;

    // Counter holds the freeze cycles still owed after the hazard cycle itself.
    localparam logic [3:0] STALL_INIT = 4'(STALL_CYCLES - 1);

    state_t     r_state;
    logic [7:0] r_pc;
    logic [3:0] r_cnt;

    state_t     w_state_nxt;
    logic [7:0] w_pc_nxt;
    logic [3:0] w_cnt_nxt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_pc    <= RESET_PC;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_pc    <= w_pc_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pc_nxt    = r_pc;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE, S_HALT: begin
                if (start) w_state_nxt = S_RUN;
            end
            S_RUN: begin
                if (halt_req) begin
                    w_state_nxt = S_HALT;
                end else if (branch_taken) begin
                    w_pc_nxt = branch_target;
                end else if (lu_hazard) begin
                    if (STALL_CYCLES > 1) begin
                        w_state_nxt = S_STALL;
                        w_cnt_nxt   = STALL_INIT;
                    end
                end else begin
                    w_pc_nxt = r_pc + PC_STEP;
                end
            end
            S_STALL: begin
                if (halt_req) begin
                    w_state_nxt = S_HALT;
                    w_cnt_nxt   = 4'd0;
                end else if (branch_taken) begin
                    w_state_nxt = S_RUN;
                    w_pc_nxt    = branch_target;
                    w_cnt_nxt   = 4'd0;
                end else if (r_cnt <= 4'd1) begin
                    w_state_nxt = S_RUN;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // A halt request silences every control in both RUN and STALL.
    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        case (r_state)
            S_RUN: begin
                if (!halt_req) begin
                    if (branch_taken) begin
                        pc_en      = 1'b1;
                        ifid_flush = 1'b1;
                    end else if (lu_hazard) begin
                        idex_bubble = 1'b1;
                    end else begin
                        pc_en   = 1'b1;
                        ifid_en = 1'b1;
                    end
                end
            end
            S_STALL: begin
                if (!halt_req) begin
                    if (branch_taken) begin
                        pc_en      = 1'b1;
                        ifid_flush = 1'b1;
                    end else begin
                        idex_bubble = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    assign pc    = r_pc;
    assign state = r_state;
    assign busy  = (r_state == S_RUN) || (r_state == S_STALL);

endmodule

// File: tb/tb_ifid_pipe_ctrl.sv
// Bench for ifid_pipe_ctrl: two instances (RESET_PC=00/STALL=3 and RESET_PC=FD/STALL=1)
// driven in lockstep and compared every cycle against a behavioural model.
module tb_ifid_pipe_ctrl;

  logic       CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic       RST, start, halt_req, branch_taken, lu_hazard;
  logic [7:0] branch_target;

  logic [7:0] pc_a, pc_b;
  logic       pc_en_a, ifid_en_a, ifid_flush_a, idex_bubble_a, busy_a;
  logic       pc_en_b, ifid_en_b, ifid_flush_b, idex_bubble_b, busy_b;
  logic [1:0] state_a, state_b;
  logic [14:0] o_a, o_b;

  assign o_a = {state_a, busy_a, idex_bubble_a, ifid_flush_a, ifid_en_a, pc_en_a, pc_a};
  assign o_b = {state_b, busy_b, idex_bubble_b, ifid_flush_b, ifid_en_b, pc_en_b, pc_b};

  ifid_pipe_ctrl #(.RESET_PC(8'h00), .PC_STEP(8'd1), .STALL_CYCLES(3)) dut_a (
    .CLK(CLK), .RST(RST), .start(start), .halt_req(halt_req),
    .branch_taken(branch_taken), .branch_target(branch_target), .lu_hazard(lu_hazard),
    .pc(pc_a), .pc_en(pc_en_a), .ifid_en(ifid_en_a), .ifid_flush(ifid_flush_a),
    .idex_bubble(idex_bubble_a), .busy(busy_a), .state(state_a)
  );

  ifid_pipe_ctrl #(.RESET_PC(8'hFD), .PC_STEP(8'd1), .STALL_CYCLES(1)) dut_b (
    .CLK(CLK), .RST(RST), .start(start), .halt_req(halt_req),
    .branch_taken(branch_taken), .branch_target(branch_target), .lu_hazard(lu_hazard),
    .pc(pc_b), .pc_en(pc_en_b), .ifid_en(ifid_en_b), .ifid_flush(ifid_flush_b),
    .idex_bubble(idex_bubble_b), .busy(busy_b), .state(state_b)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  // Model: mode 0=idle 1=running 2=halted; frz = freeze cycles still owed while running.
  logic [7:0] rp [2] = '{8'h00, 8'hFD};
  int         sc [2] = '{3, 1};
  int         m_mode [2] = '{0, 0};
  int         m_frz  [2] = '{0, 0};
  logic [7:0] m_pc   [2] = '{8'h00, 8'hFD};
  logic [14:0] exp_v [2];

  function automatic logic [14:0] model_out(int k);
    logic [1:0] st;
    logic bz, bub, fl, en, pe;
    st = 2'b00; bz = 1'b0; bub = 1'b0; fl = 1'b0; en = 1'b0; pe = 1'b0;
    if (m_mode[k] == 1) begin
      bz = 1'b1;
      st = (m_frz[k] > 0) ? 2'b10 : 2'b01;
      if (!halt_req) begin
        if (branch_taken) begin
          pe = 1'b1; fl = 1'b1;
        end else if (m_frz[k] > 0 || lu_hazard) begin
          bub = 1'b1;
        end else begin
          pe = 1'b1; en = 1'b1;
        end
      end
    end else if (m_mode[k] == 2) begin
      st = 2'b11;
    end
    return {st, bz, bub, fl, en, pe, m_pc[k]};
  endfunction

  task automatic model_step(int k);
    if (RST) begin
      m_mode[k] = 0; m_pc[k] = rp[k]; m_frz[k] = 0;
    end else if (m_mode[k] != 1) begin
      if (start) m_mode[k] = 1;
    end else if (halt_req) begin
      m_mode[k] = 2; m_frz[k] = 0;
    end else if (branch_taken) begin
      m_pc[k] = branch_target; m_frz[k] = 0;
    end else if (m_frz[k] > 0) begin
      m_frz[k] = m_frz[k] - 1;
    end else if (lu_hazard) begin
      m_frz[k] = sc[k] - 1;
    end else begin
      m_pc[k] = m_pc[k] + 8'd1;
    end
  endtask

  function automatic logic [14:0] got_v(int k);
    return (k == 0) ? o_a : o_b;
  endfunction

  task automatic drive(input logic rst, input logic st, input logic hr, input logic bt,
                       input logic [7:0] tg, input logic lu);
    RST = rst; start = st; halt_req = hr; branch_taken = bt; branch_target = tg; lu_hazard = lu;
    exp_v[0] = model_out(0);
    exp_v[1] = model_out(1);
    #4;
  endtask

  task automatic tick();
    @(posedge CLK);
    model_step(0);
    model_step(1);
    cyc++;
    #1;
  endtask

  task automatic reset_and_start();
    drive(1, 0, 0, 0, 8'h00, 0); tick();
    drive(0, 1, 0, 0, 8'h00, 0); tick();
  endtask

  task automatic test_reset();
    drive(1, 0, 0, 0, 8'h00, 0); tick();
    for (int i = 0; i < 2; i++) begin
      drive(i == 0, 0, 0, 0, 8'h00, 0);
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (got_v(k) !== exp_v[k])
          $display("FAIL reset dut%0d cyc=%0d got=%h exp=%h", k, cyc, got_v(k), exp_v[k]);
        else n_pass++;
      end
      tick();
    end
    drive(0, 0, 0, 0, 8'h00, 0);
    n_checks++;
    if ({state_a, busy_a, idex_bubble_a, ifid_flush_a, ifid_en_a, pc_en_a} !== 7'd0 ||
        pc_a !== 8'h00 || pc_b !== 8'hFD)
      $display("FAIL reset_values got pc_a=%h pc_b=%h state=%b exp pc_a=00 pc_b=fd state=00",
               pc_a, pc_b, state_a);
    else n_pass++;
    tick();
  endtask

  task automatic test_start_wrap();
    logic [7:0] exp_a, exp_b;
    drive(0, 1, 0, 0, 8'h00, 0); tick();
    for (int i = 0; i < 6; i++) begin
      drive(0, 0, 0, 0, 8'h00, 0);
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (got_v(k) !== exp_v[k])
          $display("FAIL start_wrap dut%0d cyc=%0d got=%h exp=%h", k, cyc, got_v(k), exp_v[k]);
        else n_pass++;
      end
      exp_a = 8'(i);
      exp_b = 8'(8'hFD + i);
      n_checks++;
      if (pc_a !== exp_a || pc_b !== exp_b || state_a !== 2'b01 || pc_en_a !== 1'b1 || ifid_en_a !== 1'b1)
        $display("FAIL start_wrap_seq i=%0d got pc_a=%h pc_b=%h exp pc_a=%h pc_b=%h", i, pc_a, pc_b, exp_a, exp_b);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_branch();
    int n;
    reset_and_start();
    n = 0;
    while (m_pc[0] != 8'h10 && n < 64) begin
      drive(0, 0, 0, 0, 8'h00, 0);
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (got_v(k) !== exp_v[k])
          $display("FAIL branch dut%0d cyc=%0d got=%h exp=%h", k, cyc, got_v(k), exp_v[k]);
        else n_pass++;
      end
      tick();
      n++;
    end
    drive(0, 0, 0, 1, 8'h40, 0);
    n_checks++;
    if (pc_a !== 8'h10 || ifid_flush_a !== 1'b1 || ifid_en_a !== 1'b0 || pc_en_a !== 1'b1)
      $display("FAIL branch_cycle got pc=%h flush=%b en=%b exp pc=10 flush=1 en=0", pc_a, ifid_flush_a, ifid_en_a);
    else n_pass++;
    tick();
    drive(0, 0, 0, 0, 8'h00, 0);
    n_checks++;
    if (pc_a !== 8'h40 || pc_b !== 8'h40 || state_a !== 2'b01)
      $display("FAIL branch_target got pc_a=%h pc_b=%h exp 40", pc_a, pc_b);
    else n_pass++;
    tick();
  endtask

  task automatic test_load_use();
    logic [1:0] es  [5] = '{2'b01, 2'b10, 2'b10, 2'b01, 2'b01};
    logic       eb  [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic [7:0] ep  [5] = '{8'h05, 8'h05, 8'h05, 8'h05, 8'h06};
    int n;
    reset_and_start();
    n = 0;
    while (m_pc[0] != 8'h05 && n < 32) begin
      drive(0, 0, 0, 0, 8'h00, 0); tick(); n++;
    end
    for (int j = 0; j < 5; j++) begin
      drive(0, 0, 0, 0, 8'h00, j == 0);
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (got_v(k) !== exp_v[k])
          $display("FAIL load_use dut%0d cyc=%0d got=%h exp=%h", k, cyc, got_v(k), exp_v[k]);
        else n_pass++;
      end
      n_checks++;
      if (state_a !== es[j] || idex_bubble_a !== eb[j] || pc_a !== ep[j])
        $display("FAIL load_use_seq j=%0d got st=%b bub=%b pc=%h exp st=%b bub=%b pc=%h",
                 j, state_a, idex_bubble_a, pc_a, es[j], eb[j], ep[j]);
      else n_pass++;
      tick();
    end
  endtask

  task automatic test_branch_in_stall();
    reset_and_start();
    drive(0, 0, 0, 0, 8'h00, 0); tick();
    drive(0, 0, 0, 0, 8'h00, 1); tick();
    drive(0, 0, 0, 1, 8'h80, 0);
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (got_v(k) !== exp_v[k])
        $display("FAIL branch_stall dut%0d cyc=%0d got=%h exp=%h", k, cyc, got_v(k), exp_v[k]);
      else n_pass++;
    end
    n_checks++;
    if (state_a !== 2'b10 || ifid_flush_a !== 1'b1 || ifid_en_a !== 1'b0 || idex_bubble_a !== 1'b0)
      $display("FAIL branch_stall_cycle got st=%b flush=%b bub=%b exp st=10 flush=1 bub=0",
               state_a, ifid_flush_a, idex_bubble_a);
    else n_pass++;
    tick();
    drive(0, 0, 0, 0, 8'h00, 0);
    n_checks++;
    if (state_a !== 2'b01 || pc_a !== 8'h80 || idex_bubble_a !== 1'b0)
      $display("FAIL branch_stall_after got st=%b pc=%h exp st=01 pc=80", state_a, pc_a);
    else n_pass++;
    tick();
  endtask

  task automatic test_halt_resume();
    logic [7:0] held;
    reset_and_start();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 8'h00, 0); tick();
    end
    held = m_pc[0];
    drive(0, 0, 1, 1, 8'h33, 0);
    n_checks++;
    if ({idex_bubble_a, ifid_flush_a, ifid_en_a, pc_en_a} !== 4'd0)
      $display("FAIL halt_cycle got ctl=%b exp 0000", {idex_bubble_a, ifid_flush_a, ifid_en_a, pc_en_a});
    else n_pass++;
    tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 1)));
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (got_v(k) !== exp_v[k])
          $display("FAIL halt dut%0d cyc=%0d got=%h exp=%h", k, cyc, got_v(k), exp_v[k]);
        else n_pass++;
      end
      n_checks++;
      if (state_a !== 2'b11 || pc_a !== held || busy_a !== 1'b0)
        $display("FAIL halt_hold got st=%b pc=%h exp st=11 pc=%h", state_a, pc_a, held);
      else n_pass++;
      tick();
    end
    drive(0, 1, 0, 0, 8'h00, 0); tick();
    drive(0, 0, 0, 0, 8'h00, 0);
    n_checks++;
    if (state_a !== 2'b01 || pc_a !== held || pc_en_a !== 1'b1)
      $display("FAIL resume got st=%b pc=%h exp st=01 pc=%h", state_a, pc_a, held);
    else n_pass++;
    tick();
    drive(0, 0, 0, 0, 8'h00, 1); tick();
    drive(1, 0, 0, 0, 8'h00, 0);
    n_checks++;
    if (state_a !== 2'b10)
      $display("FAIL stall_before_rst got st=%b exp st=10", state_a);
    else n_pass++;
    tick();
    drive(0, 0, 0, 0, 8'h00, 0);
    n_checks++;
    if ({state_a, busy_a, idex_bubble_a, ifid_flush_a, ifid_en_a, pc_en_a} !== 7'd0 || pc_a !== 8'h00)
      $display("FAIL rst_in_stall got st=%b pc=%h exp st=00 pc=00", state_a, pc_a);
    else n_pass++;
    tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 39) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 11) == 0,
            $urandom_range(0, 5) == 0, 8'($urandom), $urandom_range(0, 4) == 0);
      for (int k = 0; k < 2; k++) begin
        n_checks++;
        if (got_v(k) !== exp_v[k])
          $display("FAIL random dut%0d cyc=%0d got=%h exp=%h", k, cyc, got_v(k), exp_v[k]);
        else n_pass++;
      end
      n_checks++;
      if (ifid_en_a === 1'b1 && ifid_flush_a === 1'b1)
        $display("FAIL random_excl cyc=%0d got en=1 flush=1 exp not both", cyc);
      else n_pass++;
      tick();
    end
  endtask

  initial begin
    RST = 1'b1; start = 1'b0; halt_req = 1'b0; branch_taken = 1'b0;
    branch_target = 8'h00; lu_hazard = 1'b0;
    @(posedge CLK);
    #1;
    test_reset();
    test_start_wrap();
    test_branch();
    test_load_use();
    test_branch_in_stall();
    test_halt_resume();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
